// File: rtl/stage2_sched.sv
// stage2_sched: step/stage sequencer for the stage-2 normalise/compare datapath.
// Runs one pass over the operand stream, advancing the step counter on every
// accepted operand and mapping the step onto a datapath stage via the latched
// boundaries. A one-deep output register carries the stage tag to the sink.
// Optional feature macro: STAGE2_SCHED_PERF_EN adds the perf_stall_o counter.
module stage2_sched #(
    parameter int PARA   = 16,
    parameter int NBOUND = 7
) (
    input  logic                   CLK_i,
    input  logic                   RST_i,
    input  logic                   start_i,
    input  logic [NBOUND*PARA-1:0] cfg_boundary_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [2:0]             out_stage_o,
    output logic [PARA-1:0]        step_o,
    output logic [2:0]             stage_o,
    output logic                   mode_o,
    output logic                   stall_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   cfg_err_o
`ifdef STAGE2_SCHED_PERF_EN
    ,
    output logic [31:0]            perf_stall_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                         state_r;
    state_t                         state_s;
    logic [NBOUND-1:0][PARA-1:0]    bnd_r;
    logic [PARA-1:0]                step_r;
    logic [2:0]                     stage_r;
    logic                           out_valid_r;
    logic [2:0]                     out_stage_r;
    logic                           cfg_err_r;

    logic                           in_ready_s;
    logic                           fire_s;
    logic                           start_acc_s;
    logic                           stall_s;
    logic [PARA-1:0]                step_nxt_s;
    logic [2:0]                     stage_nxt_s;

    // Largest k whose lower boundary the step has passed; 0 when none.
    function automatic logic [2:0] stage_of(input logic [PARA-1:0] step,
                                            input logic [NBOUND-1:0][PARA-1:0] bnd);
        logic [2:0] stg;
        stg = 3'd0;
        for (int k = 1; k <= NBOUND; k++) begin
            stg = (step > bnd[k-1]) ? 3'(k) : stg;
        end
        return stg;
    endfunction

    // True when any boundary is smaller than its predecessor.
    function automatic logic order_bad(input logic [NBOUND-1:0][PARA-1:0] bnd);
        logic bad;
        bad = 1'b0;
        for (int k = 1; k < NBOUND; k++) begin
            bad = bad | (bnd[k] < bnd[k-1]);
        end
        return bad;
    endfunction

    // Handshake, accepted-start and next step/stage decode.
    always_comb begin
        in_ready_s  = (state_r == S_RUN) & (~out_valid_r | out_ready_i);
        fire_s      = in_ready_s & in_valid_i;
        start_acc_s = (state_r == S_IDLE) & start_i;
        stall_s     = out_valid_r & ~out_ready_i;
        step_nxt_s  = step_r + PARA'(1'b1);
        stage_nxt_s = stage_of(step_nxt_s, bnd_r);
    end

    // Pass sequencing next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_i) state_s = S_CHECK;
                else         state_s = S_IDLE;
            end
            S_CHECK: begin
                if (order_bad(bnd_r)) state_s = S_IDLE;
                else                  state_s = S_RUN;
            end
            S_RUN: begin
                if (fire_s && (stage_nxt_s == 3'(NBOUND))) state_s = S_DRAIN;
                else                                       state_s = S_RUN;
            end
            S_DRAIN: begin
                if (~out_valid_r | out_ready_i) state_s = S_DONE;
                else                            state_s = S_DRAIN;
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) state_r <= S_IDLE;
        else       state_r <= state_s;
    end

    // Boundary latch plus step/stage counters; stage only moves on a fire.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            bnd_r   <= {(NBOUND*PARA){1'b0}};
            step_r  <= {PARA{1'b0}};
            stage_r <= 3'd0;
        end else if (start_acc_s) begin
            bnd_r   <= cfg_boundary_i;
            step_r  <= {PARA{1'b0}};
            stage_r <= 3'd0;
        end else if (fire_s) begin
            step_r  <= step_nxt_s;
            stage_r <= stage_nxt_s;
        end else begin
            step_r  <= step_r;
            stage_r <= stage_r;
        end
    end

    // Result register: a fire reloads it (tagged with the pre-update stage),
    // otherwise a sink acceptance empties it.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            out_valid_r <= 1'b0;
            out_stage_r <= 3'd0;
        end else if (fire_s) begin
            out_valid_r <= 1'b1;
            out_stage_r <= stage_r;
        end else if (out_valid_r && out_ready_i) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Sticky configuration error, cleared by the next accepted start.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i)                                     cfg_err_r <= 1'b0;
        else if (start_acc_s)                          cfg_err_r <= 1'b0;
        else if (state_r == S_CHECK && order_bad(bnd_r)) cfg_err_r <= 1'b1;
        else                                           cfg_err_r <= cfg_err_r;
    end

`ifdef STAGE2_SCHED_PERF_EN
    logic [31:0] perf_r;

    // Saturating count of stalled cycles while a pass is moving data.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i)            perf_r <= 32'd0;
        else if (start_acc_s) perf_r <= 32'd0;
        else if ((state_r == S_RUN || state_r == S_DRAIN) && stall_s &&
                 (perf_r != 32'hFFFF_FFFF))
                              perf_r <= perf_r + 32'd1;
        else                  perf_r <= perf_r;
    end

    assign perf_stall_o = perf_r;
`endif

    assign in_ready_o  = in_ready_s;
    assign out_valid_o = out_valid_r;
    assign out_stage_o = out_stage_r;
    assign step_o      = step_r;
    assign stage_o     = stage_r;
    assign mode_o      = (stage_r != 3'd1);
    assign stall_o     = stall_s;
    assign busy_o      = (state_r != S_IDLE);
    assign done_o      = (state_r == S_DONE);
    assign cfg_err_o   = cfg_err_r;

endmodule

// File: tb/tb_stage2_sched.sv
// Bench for stage2_sched: directed passes with randomized handshakes, checked
// cycle by cycle against a behavioural model of the pass rules, plus a
// narrow-counter instance that exercises step wrap-around.
module tb_stage2_sched;

    localparam int PARA = 16;
    localparam int NB   = 7;
    localparam int P_IDLE = 0, P_CHECK = 1, P_RUN = 2, P_DRAIN = 3, P_DONE = 4;

    logic clk;
    logic rst;
    logic start_i, in_valid_i, out_ready_i;
    logic [NB*PARA-1:0] cfg_b;
    logic in_ready_o, out_valid_o, stall_o, busy_o, done_o, cfg_err_o, mode_o;
    logic [2:0] out_stage_o, stage_o;
    logic [PARA-1:0] step_o;
`ifdef STAGE2_SCHED_PERF_EN
    logic [31:0] perf_stall_o, w_perf;
`endif

    // narrow (PARA=4) instance used for the wrap test
    logic w_rst, w_start, w_valid;
    logic [NB*4-1:0] w_cfg;
    logic w_in_ready, w_out_valid, w_stall, w_busy, w_done, w_err, w_mode;
    logic [2:0] w_out_stage, w_stage;
    logic [3:0] w_step;

    int n_checks, n_errors;
    int cyc_no, dut_fires, last_fire_cyc, dut_done, done_cyc, dut_deliv;
    bit fin;

    // behavioural model state
    int     m_ph, m_step, m_stage, m_otag;
    bit     m_ov, m_err;
    longint m_perf;
    int     m_b[NB];
    int     exp_q[$];

    stage2_sched #(.PARA(PARA), .NBOUND(NB)) dut (
        .CLK_i(clk), .RST_i(rst), .start_i(start_i), .cfg_boundary_i(cfg_b),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_stage_o(out_stage_o), .step_o(step_o),
        .stage_o(stage_o), .mode_o(mode_o), .stall_o(stall_o), .busy_o(busy_o),
        .done_o(done_o), .cfg_err_o(cfg_err_o)
`ifdef STAGE2_SCHED_PERF_EN
        , .perf_stall_o(perf_stall_o)
`endif
    );

    stage2_sched #(.PARA(4), .NBOUND(NB)) u_wrap (
        .CLK_i(clk), .RST_i(w_rst), .start_i(w_start), .cfg_boundary_i(w_cfg),
        .in_valid_i(w_valid), .in_ready_o(w_in_ready), .out_valid_o(w_out_valid),
        .out_ready_i(1'b1), .out_stage_o(w_out_stage), .step_o(w_step),
        .stage_o(w_stage), .mode_o(w_mode), .stall_o(w_stall), .busy_o(w_busy),
        .done_o(w_done), .cfg_err_o(w_err)
`ifdef STAGE2_SCHED_PERF_EN
        , .perf_stall_o(w_perf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [NB*PARA-1:0] pack7(input int b0, input int b1, input int b2,
                                                 input int b3, input int b4, input int b5,
                                                 input int b6);
        logic [NB*PARA-1:0] v;
        int b[NB];
        b = '{b0, b1, b2, b3, b4, b5, b6};
        v = '0;
        for (int k = 0; k < NB; k++) v[k*PARA +: PARA] = 16'(b[k]);
        return v;
    endfunction

    task automatic m_reset();
        m_ph = P_IDLE; m_step = 0; m_stage = 0; m_otag = 0;
        m_ov = 1'b0; m_err = 1'b0; m_perf = 0;
        exp_q.delete();
    endtask

    // One clock of the pass rules, applied to the model.
    task automatic m_advance(input logic st, input logic iv, input logic rdy);
        bit fire, deq, bad;
        int old_stage, s;
        fire = (m_ph == P_RUN) && (!m_ov || rdy) && iv;
        deq  = m_ov && rdy;
        old_stage = m_stage;
        if ((m_ph == P_RUN || m_ph == P_DRAIN) && m_ov && !rdy && m_perf < 64'hFFFF_FFFF)
            m_perf++;
        case (m_ph)
            P_IDLE: if (st) begin
                for (int k = 0; k < NB; k++) m_b[k] = int'(cfg_b[k*PARA +: PARA]);
                m_step = 0; m_stage = 0; m_err = 1'b0; m_perf = 0; m_ph = P_CHECK;
            end
            P_CHECK: begin
                bad = 1'b0;
                for (int k = 1; k < NB; k++) if (m_b[k] < m_b[k-1]) bad = 1'b1;
                if (bad) begin m_err = 1'b1; m_ph = P_IDLE; end
                else m_ph = P_RUN;
            end
            P_RUN: if (fire) begin
                m_step = (m_step + 1) % (1 << PARA);
                s = 0;
                for (int k = 0; k < NB; k++) if (m_step > m_b[k]) s++;
                m_stage = s;
                if (m_stage == NB) m_ph = P_DRAIN;
            end
            P_DRAIN: if (!m_ov || rdy) m_ph = P_DONE;
            default: m_ph = P_IDLE;
        endcase
        if (fire) begin
            m_ov = 1'b1; m_otag = old_stage; exp_q.push_back(old_stage);
        end else if (deq) begin
            m_ov = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, compare every output with the model, advance.
    task automatic cyc(input logic st, input logic iv, input logic rdy);
        int tag_exp;
        start_i = st; in_valid_i = iv; out_ready_i = rdy;
        #1;
        chk("in_ready",  32'(in_ready_o),  32'((m_ph == P_RUN) && (!m_ov || rdy)));
        chk("out_valid", 32'(out_valid_o), 32'(m_ov));
        chk("out_stage", 32'(out_stage_o), m_otag);
        chk("step",      32'(step_o),      m_step);
        chk("stage",     32'(stage_o),     m_stage);
        chk("mode",      32'(mode_o),      32'(m_stage != 1));
        chk("stall",     32'(stall_o),     32'(m_ov && !rdy));
        chk("busy",      32'(busy_o),      32'(m_ph != P_IDLE));
        chk("done",      32'(done_o),      32'(m_ph == P_DONE));
        chk("cfg_err",   32'(cfg_err_o),   32'(m_err));
`ifdef STAGE2_SCHED_PERF_EN
        chk("perf",      perf_stall_o,     32'(m_perf));
`endif
        if (out_valid_o && out_ready_i) begin
            dut_deliv++;
            tag_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8;
            chk("sb_tag", 32'(out_stage_o), tag_exp);
        end
        if (in_ready_o && in_valid_i) begin dut_fires++; last_fire_cyc = cyc_no; end
        if (done_o) begin dut_done++; done_cyc = cyc_no; end
        m_advance(st, iv, rdy);
        cyc_no++;
        @(posedge clk); #1;
    endtask

    // One start plus the pass; mode 0 full rate, 1 five-cycle sink stall, 2 random.
    task automatic run_pass(input logic [NB*PARA-1:0] cfg, input int mode,
                            input int restart_at, output bit done_ok);
        logic iv, rdy, st;
        cfg_b = cfg;
        dut_fires = 0; dut_done = 0; dut_deliv = 0; last_fire_cyc = -100; done_cyc = -1;
        cyc(1'b1, 1'b0, 1'b1);
        done_ok = 1'b0;
        for (int c = 0; c < 400 && !done_ok; c++) begin
            case (mode)
                0:       begin iv = 1'b1; rdy = 1'b1; end
                1:       begin iv = 1'b1; rdy = !(c >= 4 && c <= 8); end
                default: begin iv = ($urandom_range(0, 3) != 0); rdy = ($urandom_range(0, 3) != 0); end
            endcase
            st = (c == restart_at);
            if (st) cfg_b = ~cfg;
            cyc(st, iv, rdy);
            if (!busy_o) done_ok = 1'b1;
        end
        chk("pass_finished", 32'(done_ok), 32'd1);
    endtask

    task automatic check_reset();
        #0;
        chk("rst_in_ready",  32'(in_ready_o),  32'd0);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_out_stage", 32'(out_stage_o), 32'd0);
        chk("rst_step",      32'(step_o),      32'd0);
        chk("rst_stage",     32'(stage_o),     32'd0);
        chk("rst_mode",      32'(mode_o),      32'd1);
        chk("rst_stall",     32'(stall_o),     32'd0);
        chk("rst_busy",      32'(busy_o),      32'd0);
        chk("rst_done",      32'(done_o),      32'd0);
        chk("rst_cfg_err",   32'(cfg_err_o),   32'd0);
`ifdef STAGE2_SCHED_PERF_EN
        chk("rst_perf",      perf_stall_o,     32'd0);
`endif
    endtask

    initial begin
        logic [NB*PARA-1:0] cfg_a;
        int rb[NB];
        n_checks = 0; n_errors = 0; cyc_no = 0;
        dut_fires = 0; dut_done = 0; dut_deliv = 0; last_fire_cyc = 0; done_cyc = 0;
        rst = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1; cfg_b = '0;
        w_rst = 1'b1; w_start = 1'b0; w_valid = 1'b0; w_cfg = 28'hF00_0000;
        m_reset();
        cfg_a = pack7(0, 2, 4, 6, 8, 10, 12);

        // reset values
        #3;
        check_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; w_rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // full-rate pass
        run_pass(cfg_a, 0, -1, fin);
        chk("A_fires",    dut_fires, 13);
        chk("A_deliv",    dut_deliv, 13);
        chk("A_done_cnt", dut_done, 1);
        chk("A_done_lat", done_cyc - last_fire_cyc, 2);

        // sink stalls for five cycles mid-run
        run_pass(cfg_a, 1, -1, fin);
        chk("B_fires",    dut_fires, 13);
        chk("B_deliv",    dut_deliv, 13);
        chk("B_sb_empty", exp_q.size(), 0);
`ifdef STAGE2_SCHED_PERF_EN
        chk("B_perf",     perf_stall_o, 5);
`endif

        // decreasing boundaries
        run_pass(pack7(5, 3, 1, 0, 0, 0, 0), 0, -1, fin);
        chk("C_cfg_err",  32'(cfg_err_o), 32'd1);
        chk("C_busy",     32'(busy_o), 32'd0);
        chk("C_done_cnt", dut_done, 0);
        chk("C_fires",    dut_fires, 0);

        // random sorted boundaries with random handshakes
        repeat (3) begin
            rb[0] = $urandom_range(0, 3);
            for (int k = 1; k < NB; k++) rb[k] = rb[k-1] + $urandom_range(0, 4);
            run_pass(pack7(rb[0], rb[1], rb[2], rb[3], rb[4], rb[5], rb[6]), 2, -1, fin);
            chk("R_fires",    dut_fires, rb[6] + 1);
            chk("R_deliv",    dut_deliv, rb[6] + 1);
            chk("R_cfg_err",  32'(cfg_err_o), 32'd0);
            chk("R_done_cnt", dut_done, 1);
        end

        // start re-pulsed during RUN (with different boundaries on the bus)
        run_pass(cfg_a, 0, 5, fin);
        chk("E_fires",    dut_fires, 13);
        chk("E_done_cnt", dut_done, 1);

        // asynchronous reset mid-run at step 4
        cfg_b = cfg_a;
        cyc(1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 20 && step_o != 16'd4; c++) cyc(1'b0, 1'b1, 1'b1);
        chk("F_step4", 32'(step_o), 32'd4);
        #3;
        rst = 1'b1;
        #1;
        check_reset();
        m_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        run_pass(cfg_a, 0, -1, fin);
        chk("F_fires",    dut_fires, 13);
        chk("F_done_cnt", dut_done, 1);

        // 4-bit step counter wraps before reaching the last stage
        w_start = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        w_start = 1'b0; w_valid = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        repeat (15) cyc(1'b0, 1'b0, 1'b1);
        chk("W_step15",  32'(w_step),  32'd15);
        chk("W_stage6",  32'(w_stage), 32'd6);
        cyc(1'b0, 1'b0, 1'b1);
        chk("W_step0",   32'(w_step),  32'd0);
        chk("W_stage0",  32'(w_stage), 32'd0);
        chk("W_mode",    32'(w_mode),  32'd1);
        chk("W_busy",    32'(w_busy),  32'd1);
        w_valid = 1'b0;
        w_rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
